// File: rtl/fft_frame_streamer_if.sv
// Stream bundle between the CORDIC magnitude stage, the frame streamer and the peak finder.
// slave: the streamer side; master: the upstream/downstream environment side.
interface fft_frame_streamer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              t_valid;
    logic [DATA_W-1:0] fft_val;
    logic              pf_done;

    modport slave (
        input  in_valid, in_data, in_last, pf_done,
        output in_ready, t_valid, fft_val
    );

    modport master (
        output in_valid, in_data, in_last, pf_done,
        input  in_ready, t_valid, fft_val
    );
endinterface

// File: rtl/fft_frame_streamer.sv
// Captures one FFT magnitude frame, replays it as a contiguous t_valid burst, then waits for pf_done.
// Define FFT_STREAMER_PINGPONG_EN for two banks so capture overlaps transmission.
module fft_frame_streamer #(
    parameter int FFT_SIZE = 1024,
    parameter int DATA_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    fft_frame_streamer_if.slave        bus,
    output logic                       busy,
    output logic [15:0]                frame_count,
    output logic                       frame_err,
    output logic                       overflow
);
`ifdef FFT_STREAMER_PINGPONG_EN
    localparam int   BANKS = 2;
    localparam logic PP    = 1'b1;
`else
    localparam int   BANKS = 1;
    localparam logic PP    = 1'b0;
`endif
    localparam int IW = $clog2(FFT_SIZE);
    localparam int AW = $clog2(BANKS * FFT_SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(FFT_SIZE - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT_DONE} state_t;

    logic [DATA_W-1:0] mem [BANKS*FFT_SIZE];
    logic [DATA_W-1:0] rd_data_q;

    state_t        state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic          resync_q, resync_d;
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          t_valid_q, t_valid_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          frame_err_q, frame_err_d;
    logic          in_ready_q, in_ready_d;
    logic          overflow_q, overflow_d;
    logic          busy_q, busy_d;
    logic          accept, we;
    logic [AW-1:0] wr_addr, rd_addr;

    assign accept  = bus.in_valid & in_ready_q;
    assign wr_addr = AW'({wr_bank_q, wr_idx_q});
    assign rd_addr = AW'({rd_bank_q, rd_idx_q});

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        resync_d      = resync_q;
        full_d        = full_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        t_valid_d     = t_valid_q;
        frame_count_d = frame_count_q;
        frame_err_d   = 1'b0;
        we            = 1'b0;

        // Long frames leave resync set; beats are swallowed until the next in_last realigns.
        if (accept) begin
            if (resync_q) begin
                if (bus.in_last) begin
                    resync_d = 1'b0;
                    wr_idx_d = '0;
                end
            end else begin
                we = 1'b1;
                if (wr_idx_q == LAST_IDX) begin
                    wr_idx_d = '0;
                    if (bus.in_last) begin
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = wr_bank_q ^ PP;
                    end else begin
                        frame_err_d = 1'b1;
                        resync_d    = 1'b1;
                    end
                end else if (bus.in_last) begin
                    frame_err_d = 1'b1;
                    wr_idx_d    = '0;
                end else begin
                    wr_idx_d = wr_idx_q + IW'(1);
                end
            end
        end

        // rd_idx runs one ahead of the beat on the bus and rests at 0 outside SEND.
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_idx_d  = IW'(1);
                    t_valid_d = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (rd_idx_q == '0) begin
                    t_valid_d = 1'b0;
                    state_d   = GAP;
                end else begin
                    rd_idx_d = rd_idx_q + IW'(1);
                end
            end
            GAP: begin
                frame_count_d = frame_count_q + 16'd1;
                state_d       = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.pf_done) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = rd_bank_q ^ PP;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = ~full_d[wr_bank_d];
        overflow_d = overflow_q | (bus.in_valid & ~in_ready_q);
        busy_d     = (full_d != 2'b00) || (wr_idx_d != '0) || resync_d || (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            resync_q      <= 1'b0;
            full_q        <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            t_valid_q     <= 1'b0;
            frame_count_q <= '0;
            frame_err_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            resync_q      <= resync_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            t_valid_q     <= t_valid_d;
            frame_count_q <= frame_count_d;
            frame_err_q   <= frame_err_d;
            in_ready_q    <= in_ready_d;
            overflow_q    <= overflow_d;
            busy_q        <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= bus.in_data;
        rd_data_q <= mem[rd_addr];
    end

    assign bus.in_ready = in_ready_q;
    assign bus.t_valid  = t_valid_q;
    assign bus.fft_val  = t_valid_q ? rd_data_q : '0;
    assign busy         = busy_q;
    assign frame_count  = frame_count_q;
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;
endmodule
